// File: rtl/gf_log_seq.sv
// -----------------------------------------------------------------------------
// gf_log_seq : GF(2^8) discrete logarithm by sequential search.
//
// An accepted element is compared against successive powers of alpha, one per
// clock, starting at alpha^0. The matching exponent is returned. A zero input
// has no log and is flagged on out_zero instead.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake; accepted only in IDLE
//   in_elem            element whose log is requested
//   out_valid/out_ready result handshake; result held until out_ready
//   out_index          exponent n with alpha^n == in_elem (0..254)
//   out_zero           input was zero, log undefined
//   busy               high while searching
// -----------------------------------------------------------------------------
module gf_log_seq #(
   parameter logic [7:0] POLY_LOW = 8'h5F   // alpha^8 reduced, low 8 bits
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_elem,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_index,
   output logic       out_zero,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_t;

   state_t     state_q, state_d;
   logic [7:0] target_q, target_d;
   logic [7:0] acc_q, acc_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] idx_q, idx_d;
   logic       zero_q, zero_d;
   logic [7:0] acc_mul;

   // acc * alpha: shift up and fold the overflowed x^8 term back in
   assign acc_mul = {acc_q[6:0], 1'b0} ^ (acc_q[7] ? POLY_LOW : 8'h00);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         target_q <= 8'h00;
         acc_q    <= 8'h01;
         cnt_q    <= 8'h00;
         idx_q    <= 8'h00;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         zero_q   <= zero_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = SEARCH;
         SEARCH:  if ((target_q == 8'h00) || (acc_q == target_q) || (cnt_q == 8'd254))
                     state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      target_d = target_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      zero_d   = zero_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               target_d = in_elem;
               acc_d    = 8'h01;
               cnt_d    = 8'h00;
            end
         end
         SEARCH: begin
            if (target_q == 8'h00) begin
               zero_d = 1'b1;
               idx_d  = 8'h00;
            end else if (acc_q == target_q) begin
               zero_d = 1'b0;
               idx_d  = cnt_q;
            end else if (cnt_q == 8'd254) begin
               // exhausted the group without a match: only possible with a
               // non-primitive POLY_LOW, report as undefined
               zero_d = 1'b1;
               idx_d  = 8'h00;
            end else begin
               acc_d = acc_mul;
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == SEARCH);
      out_index = idx_q;
      out_zero  = zero_q;
   end

endmodule

// File: doc/gf_log_seq.md
GF_LOG_SEQ -- requirements
Module: gf_log_seq

Interface
REQ-001 The block SHALL have parameter POLY_LOW, default 8'h5F, meaning the low 8 bits of the primitive polynomial x^8+x^6+x^4+x^3+x^2+x+1 (the value of alpha^8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_elem is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an element.
REQ-006 The block SHALL have port in_elem, input, 8 bits: GF(2^8) element whose log is requested.
REQ-007 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-009 The block SHALL have port out_index, output, 8 bits: n such that alpha^n = in_elem, range 0..254.
REQ-010 The block SHALL have port out_zero, output, 1 bit: input was 0 (log undefined).
REQ-011 The block SHALL have port busy, output, 1 bit: high in SEARCH.

Function
REQ-012 The block SHALL compute the inverse of the GF(2^8) antilog table (element -> exponent) by sequential search, not by a 256-entry lookup.
REQ-013 The block SHALL implement FSM states IDLE, SEARCH and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in SEARCH and DONE, in_ready SHALL be 0.
REQ-015 Acceptance SHALL occur at the edge where in_valid=1 and in_ready=1; at that edge: capture in_elem into target, set acc=8'h01, cnt=0, go to SEARCH.
REQ-016 At each SEARCH edge, if target==0, the block SHALL set out_zero=1 and out_index=0 and go to DONE.
REQ-017 Otherwise at each SEARCH edge, if acc==target, the block SHALL set out_index=cnt and out_zero=0 and go to DONE.
REQ-018 Otherwise at each SEARCH edge, the block SHALL set acc = acc*alpha (shift left 1; if old acc[7]=1, XOR POLY_LOW) and cnt = cnt+1.
REQ-019 Latency: for nonzero input with log n, out_valid SHALL rise n+1 edges after the acceptance edge (1..255); for zero input, 1 edge after.
REQ-020 In DONE, out_valid SHALL be 1, and out_index and out_zero SHALL be held stable until the edge where out_ready=1; at that edge the block SHALL go to IDLE.
REQ-021 If out_ready=1 while DONE, no new element SHALL be accepted in that same cycle (in_ready=0); the next acceptance is possible at the earliest one cycle later.
REQ-022 in_elem changes while not in IDLE SHALL be ignored.
REQ-023 cnt SHALL be 8 bits and never exceed 254 for nonzero input.
REQ-024 If SEARCH reaches cnt==254 without a match (unreachable for a valid polynomial), the block SHALL go to DONE with out_zero=1 as a safety exit.
REQ-025 out_valid SHALL be 0 in IDLE and in SEARCH.
REQ-026 busy SHALL equal (state==SEARCH).

Reset
REQ-027 On rst_n=0, asynchronously: state=IDLE, target=0, acc=8'h01, cnt=0, out_index=0, out_zero=0; outputs in_ready=1, out_valid=0, busy=0.
REQ-028 Reset asserted mid-SEARCH or mid-DONE SHALL abandon the operation with no result emitted; after release, the first acceptance SHALL behave as from power-up.

Verification
REQ-029 The bench SHALL cover: in_elem=8'h01 accepted -> out_valid after 1 edge, out_index=0, out_zero=0.
REQ-030 The bench SHALL cover: in_elem=8'h5F -> out_index=8 after 9 edges; in_elem=8'h02 -> 1 after 2 edges.
REQ-031 The bench SHALL cover: in_elem=8'hAF -> out_index=254 after 255 edges (worst case); busy high for exactly 255 cycles.
REQ-032 The bench SHALL cover: in_elem=8'h00 -> out_zero=1, out_index=0 after 1 edge.
REQ-033 The bench SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_valid/out_index stable; in_valid=1 with a new element during that time -> not accepted.
REQ-034 The bench SHALL cover: exhaustive sweep of all 256 inputs checked against the antilog table (alpha^out_index == in_elem), plus reset asserted during a SEARCH of 8'hAF -> in_ready=1 and out_valid=0 immediately, followed by a correct next result.
